// File: rtl/kmeans_centroid_update_k2_d5_if.sv
// Sample/flush inputs and centroid result outputs of the k=2, d=5 centroid-update stage.
// master drives samples and flush; slave is the centroid-update block.
interface kmeans_centroid_update_k2_d5_if #(
   parameter int DATA_W = 16,
   parameter int ID_W   = 1,
   parameter int CNT_W  = 16
);
   logic              in_valid;
   logic [DATA_W-1:0] input_data0;
   logic [DATA_W-1:0] input_data1;
   logic [DATA_W-1:0] input_data2;
   logic [DATA_W-1:0] input_data3;
   logic [DATA_W-1:0] input_data4;
   logic [ID_W-1:0]   selected_centroid;
   logic              flush;
   logic              busy;
   logic              out_valid;
   logic [DATA_W-1:0] centroid0_d0;
   logic [DATA_W-1:0] centroid0_d1;
   logic [DATA_W-1:0] centroid0_d2;
   logic [DATA_W-1:0] centroid0_d3;
   logic [DATA_W-1:0] centroid0_d4;
   logic [DATA_W-1:0] centroid1_d0;
   logic [DATA_W-1:0] centroid1_d1;
   logic [DATA_W-1:0] centroid1_d2;
   logic [DATA_W-1:0] centroid1_d3;
   logic [DATA_W-1:0] centroid1_d4;
   logic [CNT_W-1:0]  count0;
   logic [CNT_W-1:0]  count1;
   logic              overflow;

   modport master (
      output in_valid, input_data0, input_data1, input_data2, input_data3, input_data4,
      output selected_centroid, flush,
      input  busy, out_valid,
      input  centroid0_d0, centroid0_d1, centroid0_d2, centroid0_d3, centroid0_d4,
      input  centroid1_d0, centroid1_d1, centroid1_d2, centroid1_d3, centroid1_d4,
      input  count0, count1, overflow
   );

   modport slave (
      input  in_valid, input_data0, input_data1, input_data2, input_data3, input_data4,
      input  selected_centroid, flush,
      output busy, out_valid,
      output centroid0_d0, centroid0_d1, centroid0_d2, centroid0_d3, centroid0_d4,
      output centroid1_d0, centroid1_d1, centroid1_d2, centroid1_d3, centroid1_d4,
      output count0, count1, overflow
   );
endinterface

// File: rtl/kmeans_centroid_update_k2_d5.sv
// k-means (k=2, d=5) centroid update: per-centroid sums/counts, then a bit-serial divide on flush.
// Optional build macro KMEANS_ROUND_EN selects round-half-up division instead of truncation.
module kmeans_centroid_update_k2_d5 #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 32,
   parameter int CNT_W  = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   kmeans_centroid_update_k2_d5_if.slave bus
);
   localparam int K    = 2;
   localparam int D    = 5;
   localparam int IT_W = $clog2(ACC_W + 1);
   localparam logic [IT_W-1:0]  LAST_IT = IT_W'(ACC_W);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef KMEANS_ROUND_EN
   localparam bit ROUND = 1'b1;
`else
   localparam bit ROUND = 1'b0;
`endif

   typedef enum logic [1:0] {ACCUM, DIVIDE, DONE} state_t;
   state_t state, state_nxt;

   logic [DATA_W-1:0] sample   [D];
   logic [ACC_W-1:0]  acc      [K][D];
   logic [CNT_W-1:0]  cnt      [K];
   logic [DATA_W-1:0] cen      [K][D];
   logic [DATA_W-1:0] cen_new  [K][D];
   logic [DATA_W-1:0] cen_out  [K][D];
   logic [DATA_W-1:0] res      [K][D];
   logic [CNT_W-1:0]  cnt_held [K];
   logic              ovf_flag;

   logic              started;
   logic [IT_W-1:0]   iter;
   logic              div_k;
   logic [2:0]        div_d;
   logic              last_div;
   logic [ACC_W:0]    num;
   logic [CNT_W-1:0]  rem;
   logic [CNT_W-1:0]  dsr;
   logic [ACC_W-1:0]  dvd;
   logic [DATA_W-2:0] quo;
   logic [CNT_W:0]    trial;
   logic              ge;
   logic [DATA_W-1:0] q_next;

   // Numerator is one bit wider than the accumulator so the rounding bias cannot wrap.
   function automatic logic [ACC_W:0] numerator(input logic [ACC_W-1:0] a,
                                                input logic [CNT_W-1:0] c);
      logic [ACC_W:0] half;
      half = ROUND ? (ACC_W+1)'(c >> 1) : '0;
      return {1'b0, a} + half;
   endfunction

   always_comb begin
      sample[0] = bus.input_data0;
      sample[1] = bus.input_data1;
      sample[2] = bus.input_data2;
      sample[3] = bus.input_data3;
      sample[4] = bus.input_data4;
   end

   // ---- FSM ----
   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ACCUM:   if (bus.flush) state_nxt = DIVIDE;
         DIVIDE:  if (started && iter == LAST_IT && last_div) state_nxt = DONE;
         DONE:    state_nxt = ACCUM;
         default: state_nxt = ACCUM;
      endcase
   end

   // ---- divide sequencing: one start slot, then 10 x (load + ACC_W iterations) ----
   assign last_div = div_k && (div_d == 3'd4);

   always_ff @(posedge clk) begin
      if (rst) begin
         started <= 1'b0;
         iter    <= '0;
         div_k   <= 1'b0;
         div_d   <= '0;
      end else if (state == DIVIDE) begin
         if (!started) begin
            started <= 1'b1;
         end else if (iter == LAST_IT) begin
            iter <= '0;
            if (div_d == 3'd4) begin
               div_d <= '0;
               div_k <= ~div_k;
            end else begin
               div_d <= div_d + 3'd1;
            end
         end else begin
            iter <= iter + IT_W'(1);
         end
      end else begin
         started <= 1'b0;
         iter    <= '0;
         div_k   <= 1'b0;
         div_d   <= '0;
      end
   end

   // ---- restoring divider datapath ----
   assign num    = numerator(acc[div_k][div_d], cnt[div_k]);
   assign trial  = {rem, dvd[ACC_W-1]};
   assign ge     = trial >= {1'b0, dsr};
   assign q_next = {quo, ge};

   always_ff @(posedge clk) begin
      if (state == DIVIDE && started) begin
         if (iter == '0) begin
            // The numerator MSB seeds the remainder; it can only be set when cnt >= 2.
            rem <= CNT_W'(num[ACC_W]);
            dvd <= num[ACC_W-1:0];
            quo <= '0;
            dsr <= cnt[div_k];
         end else begin
            rem <= ge ? CNT_W'(trial - {1'b0, dsr}) : trial[CNT_W-1:0];
            dvd <= {dvd[ACC_W-2:0], 1'b0};
            quo <= q_next[DATA_W-2:0];
            if (iter == LAST_IT) res[div_k][div_d] <= q_next;
         end
      end
   end

   // ---- accumulate / commit ----
   always_comb begin
      for (int k = 0; k < K; k++) begin
         for (int d = 0; d < D; d++) begin
            cen_new[k][d] = (cnt[k] == '0) ? cen[k][d] : res[k][d];
            cen_out[k][d] = (state == DONE) ? cen_new[k][d] : cen[k][d];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < K; k++) begin
            for (int d = 0; d < D; d++) begin
               acc[k][d] <= '0;
               cen[k][d] <= '0;
            end
            cnt[k]      <= '0;
            cnt_held[k] <= '0;
         end
         ovf_flag <= 1'b0;
      end else begin
         case (state)
            ACCUM: begin
               if (bus.in_valid) begin
                  if (cnt[bus.selected_centroid] != CNT_MAX) begin
                     for (int d = 0; d < D; d++)
                        acc[bus.selected_centroid][d] <= acc[bus.selected_centroid][d]
                                                         + ACC_W'(sample[d]);
                     cnt[bus.selected_centroid] <= cnt[bus.selected_centroid] + CNT_W'(1);
                  end else begin
                     ovf_flag <= 1'b1;
                  end
               end
            end
            DONE: begin
               for (int k = 0; k < K; k++) begin
                  for (int d = 0; d < D; d++) begin
                     cen[k][d] <= cen_new[k][d];
                     acc[k][d] <= '0;
                  end
                  cnt_held[k] <= cnt[k];
                  cnt[k]      <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // ---- outputs: DONE presents the fresh results while they are committed ----
   assign bus.busy         = (state != ACCUM);
   assign bus.out_valid    = (state == DONE);
   assign bus.overflow     = ovf_flag;
   assign bus.count0       = (state == DONE) ? cnt[0] : cnt_held[0];
   assign bus.count1       = (state == DONE) ? cnt[1] : cnt_held[1];
   assign bus.centroid0_d0 = cen_out[0][0];
   assign bus.centroid0_d1 = cen_out[0][1];
   assign bus.centroid0_d2 = cen_out[0][2];
   assign bus.centroid0_d3 = cen_out[0][3];
   assign bus.centroid0_d4 = cen_out[0][4];
   assign bus.centroid1_d0 = cen_out[1][0];
   assign bus.centroid1_d1 = cen_out[1][1];
   assign bus.centroid1_d2 = cen_out[1][2];
   assign bus.centroid1_d3 = cen_out[1][3];
   assign bus.centroid1_d4 = cen_out[1][4];
endmodule

// File: tb/tb_kmeans_centroid_update_k2_d5.sv
// Scoreboard bench for kmeans_centroid_update_k2_d5: full-width unit plus a 2-bit-counter unit.
module tb_kmeans_centroid_update_k2_d5;
   localparam int DATA_W  = 16;
   localparam int ACC_W   = 32;
   localparam int CNT_W   = 16;
   localparam int CNT_W_S = 2;
   localparam int LAT     = 10 * (ACC_W + 1) + 1;
`ifdef KMEANS_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   typedef logic [4:0][15:0] vec_t;
   typedef struct {
      vec_t c0;
      vec_t c1;
      int   n0;
      int   n1;
      bit   ov;
      int   due;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;

   exp_t  q0[$];
   exp_t  q1[$];
   longint msum [2][2][5];
   int     mcnt [2][2];
   int     mprev[2][2][5];
   int     cmax [2];
   bit     movf [2];
   int     mdue [2];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   kmeans_centroid_update_k2_d5_if #(.DATA_W(DATA_W), .ID_W(1), .CNT_W(CNT_W))   a ();
   kmeans_centroid_update_k2_d5_if #(.DATA_W(DATA_W), .ID_W(1), .CNT_W(CNT_W_S)) b ();

   kmeans_centroid_update_k2_d5 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .bus(a));
   kmeans_centroid_update_k2_d5 #(.DATA_W(DATA_W), .ACC_W(ACC_W), .CNT_W(CNT_W_S)) dut_sat (
      .clk(clk), .rst(rst), .bus(b));

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(int x0, int x1, int x2, int x3, int x4);
      vec_t v;
      v[0] = 16'(x0); v[1] = 16'(x1); v[2] = 16'(x2); v[3] = 16'(x3); v[4] = 16'(x4);
      return v;
   endfunction

   function automatic vec_t rnd_vec();
      vec_t v;
      for (int d = 0; d < 5; d++) v[d] = 16'($urandom_range(0, 65535));
      return v;
   endfunction

   function automatic void model_reset();
      for (int u = 0; u < 2; u++) begin
         for (int k = 0; k < 2; k++) begin
            mcnt[u][k] = 0;
            for (int d = 0; d < 5; d++) begin
               msum[u][k][d]  = 0;
               mprev[u][k][d] = 0;
            end
         end
         movf[u] = 1'b0;
         mdue[u] = -10;
      end
      q0.delete();
      q1.delete();
   endfunction

   // Epoch result: mean of the accepted samples, or the previous coordinate for an empty centroid.
   function automatic void model_flush(int u);
      exp_t e;
      longint q;
      for (int k = 0; k < 2; k++) begin
         for (int d = 0; d < 5; d++) begin
            if (mcnt[u][k] == 0) q = mprev[u][k][d];
            else q = (msum[u][k][d] + (RND ? mcnt[u][k] / 2 : 0)) / mcnt[u][k];
            mprev[u][k][d] = int'(q);
            if (k == 0) e.c0[d] = 16'(q);
            else        e.c1[d] = 16'(q);
            msum[u][k][d] = 0;
         end
      end
      e.n0 = mcnt[u][0];
      e.n1 = mcnt[u][1];
      e.ov = movf[u];
      e.due = cyc + 1 + LAT;
      mdue[u] = e.due;
      mcnt[u][0] = 0;
      mcnt[u][1] = 0;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endfunction

   task automatic drive_bus(int u, bit v, bit sel, vec_t x, bit fl);
      if (u == 0) begin
         a.in_valid = v; a.selected_centroid = sel; a.flush = fl;
         a.input_data0 = x[0]; a.input_data1 = x[1]; a.input_data2 = x[2];
         a.input_data3 = x[3]; a.input_data4 = x[4];
      end else begin
         b.in_valid = v; b.selected_centroid = sel; b.flush = fl;
         b.input_data0 = x[0]; b.input_data1 = x[1]; b.input_data2 = x[2];
         b.input_data3 = x[3]; b.input_data4 = x[4];
      end
   endtask

   task automatic idle_in();
      drive_bus(0, 1'b0, 1'b0, '0, 1'b0);
      drive_bus(1, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // One input cycle; the model only takes it if the unit is back in accumulate by the sampling edge.
   task automatic put(int u, bit v, bit sel, vec_t x, bit fl);
      @(negedge clk);
      idle_in();
      drive_bus(u, v, sel, x, fl);
      if (cyc >= mdue[u] + 1) begin
         if (v) begin
            if (mcnt[u][sel] < cmax[u]) begin
               for (int d = 0; d < 5; d++) msum[u][sel][d] += x[d];
               mcnt[u][sel]++;
            end else begin
               movf[u] = 1'b1;
            end
         end
         if (fl) model_flush(u);
      end
   endtask

   // Returns at the negedge inside the result cycle, so the next put lands in the first free cycle.
   task automatic wait_idle(int u);
      @(negedge clk);
      idle_in();
      while (cyc < mdue[u]) @(negedge clk);
   endtask

   task automatic compare(int u, vec_t c0, vec_t c1, int n0, int n1, bit ov);
      exp_t e;
      if ((u == 0 && q0.size() == 0) || (u == 1 && q1.size() == 0)) begin
         chk($sformatf("u%0d spurious out_valid", u), 1, 0);
      end else begin
         e = (u == 0) ? q0.pop_front() : q1.pop_front();
         chk($sformatf("u%0d latency", u), cyc, e.due);
         for (int d = 0; d < 5; d++) begin
            chk($sformatf("u%0d centroid0_d%0d", u, d), c0[d], e.c0[d]);
            chk($sformatf("u%0d centroid1_d%0d", u, d), c1[d], e.c1[d]);
         end
         chk($sformatf("u%0d count0", u), n0, e.n0);
         chk($sformatf("u%0d count1", u), n1, e.n1);
         chk($sformatf("u%0d overflow", u), ov, e.ov);
      end
   endtask

   always @(negedge clk) begin
      if (a.out_valid === 1'b1)
         compare(0, {a.centroid0_d4, a.centroid0_d3, a.centroid0_d2, a.centroid0_d1, a.centroid0_d0},
                    {a.centroid1_d4, a.centroid1_d3, a.centroid1_d2, a.centroid1_d1, a.centroid1_d0},
                    int'(a.count0), int'(a.count1), a.overflow);
   end

   always @(negedge clk) begin
      if (b.out_valid === 1'b1)
         compare(1, {b.centroid0_d4, b.centroid0_d3, b.centroid0_d2, b.centroid0_d1, b.centroid0_d0},
                    {b.centroid1_d4, b.centroid1_d3, b.centroid1_d2, b.centroid1_d1, b.centroid1_d0},
                    int'(b.count0), int'(b.count1), b.overflow);
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      cmax[0] = (1 << CNT_W) - 1;
      cmax[1] = (1 << CNT_W_S) - 1;
      model_reset();
      idle_in();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset busy", a.busy, 0);
      chk("reset out_valid", a.out_valid, 0);
      chk("reset overflow", a.overflow, 0);
      chk("reset count0", a.count0, 0);
      chk("reset centroid1_d4", a.centroid1_d4, 0);
      chk("reset sat busy", b.busy, 0);

      // empty epoch
      put(0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      idle_in();
      chk("busy after flush", a.busy, 1);
      wait_idle(0);

      // two samples to centroid 0, one to centroid 1; starts back-to-back with the previous epoch
      put(0, 1'b1, 1'b0, mk(10, 20, 30, 40, 50), 1'b0);
      put(0, 1'b1, 1'b0, mk(20, 30, 40, 50, 60), 1'b0);
      put(0, 1'b1, 1'b1, mk(100, 200, 300, 400, 500), 1'b0);
      put(0, 1'b0, 1'b0, '0, 1'b1);
      wait_idle(0);

      // rounding case, centroid 1 idle for two epochs
      put(0, 1'b1, 1'b0, mk(1, 7, 9, 0, 65535), 1'b0);
      put(0, 1'b1, 1'b0, mk(2, 8, 9, 1, 65535), 1'b0);
      put(0, 1'b0, 1'b0, '0, 1'b1);
      wait_idle(0);
      @(negedge clk);
      chk("held centroid0_d0", a.centroid0_d0, RND ? 2 : 1);
      chk("held centroid1_d0", a.centroid1_d0, 100);
      put(0, 1'b1, 1'b0, mk(5, 6, 7, 8, 9), 1'b0);
      put(0, 1'b0, 1'b0, '0, 1'b1);
      wait_idle(0);

      // sample in the flush cycle counts; pulses while busy do not
      put(0, 1'b1, 1'b0, mk(11, 12, 13, 14, 15), 1'b0);
      put(0, 1'b1, 1'b1, mk(900, 800, 700, 600, 500), 1'b1);
      for (int i = 0; i < 6; i++) put(0, 1'b1, 1'($urandom_range(0, 1)), rnd_vec(), i == 3);
      wait_idle(0);

      // random epochs
      for (int e = 0; e < 4; e++) begin
         n = $urandom_range(0, 12);
         for (int i = 0; i < n; i++)
            put(0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rnd_vec(), 1'b0);
         put(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_vec(), 1'b1);
         for (int i = 0; i < 3; i++) put(0, 1'b1, 1'($urandom_range(0, 1)), rnd_vec(), 1'b0);
         wait_idle(0);
      end

      // counter saturation on the 2-bit unit
      put(1, 1'b1, 1'b0, mk(3, 30, 300, 3000, 30000), 1'b0);
      put(1, 1'b1, 1'b0, mk(6, 60, 600, 6000, 60000), 1'b0);
      put(1, 1'b1, 1'b0, mk(9, 90, 900, 9000, 65000), 1'b0);
      put(1, 1'b1, 1'b0, mk(1000, 1000, 1000, 1000, 1000), 1'b0);
      put(1, 1'b0, 1'b0, '0, 1'b1);
      wait_idle(1);
      @(negedge clk);
      chk("sat held count0", b.count0, 3);
      chk("sat held centroid0_d1", b.centroid0_d1, 60);
      chk("sat overflow", b.overflow, 1);
      put(1, 1'b1, 1'b1, mk(4, 4, 4, 4, 4), 1'b0);
      put(1, 1'b0, 1'b0, '0, 1'b1);
      wait_idle(1);
      @(negedge clk);
      chk("sat overflow sticky", b.overflow, 1);

      // reset in the middle of a divide
      put(0, 1'b1, 1'b0, mk(40, 41, 42, 43, 44), 1'b0);
      put(0, 1'b0, 1'b0, '0, 1'b1);
      repeat (100) begin
         @(negedge clk);
         idle_in();
      end
      rst = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      chk("mid rst busy", a.busy, 0);
      chk("mid rst out_valid", a.out_valid, 0);
      chk("mid rst centroid0_d0", a.centroid0_d0, 0);
      chk("mid rst centroid1_d0", a.centroid1_d0, 0);
      chk("mid rst count0", a.count0, 0);
      chk("mid rst sat overflow", b.overflow, 0);
      repeat (300) @(negedge clk);
      put(0, 1'b1, 1'b1, mk(7, 14, 21, 28, 35), 1'b0);
      put(0, 1'b1, 1'b1, mk(9, 16, 23, 30, 37), 1'b0);
      put(0, 1'b1, 1'b0, mk(65535, 0, 65535, 0, 1), 1'b1);
      wait_idle(0);

      @(negedge clk);
      chk("u0 pending results", q0.size(), 0);
      chk("u1 pending results", q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
